mem_arb: RTL and testbench
==========================

# mem_arb

Two-to-one arbiter between the instruction-fetch requester and the MEM-stage data requester for the single shared SRAM-like bus. It sits between the IF/MEM pipeline stages and the memory bus. It latches one request at a time, sequences the address and data handshakes, and returns the response to the owning requester. It also raises a stall request to the pipeline controller while a requester is waiting.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- inst_req  in  1  fetch request; held stable until inst_gnt
- inst_addr  in  AW  fetch address
- inst_gnt  out  1  fetch request captured this cycle
- inst_rvalid  out  1  one-cycle pulse; fetch response
- inst_rdata  out  DW  fetch data; valid with inst_rvalid
- data_req  in  1  load/store request; held stable until data_gnt
- data_wen  in  4  byte write strobes; 0 means load
- data_addr  in  AW  load/store address
- data_wdata  in  DW  store data
- data_gnt  out  1  data request captured this cycle
- data_rvalid  out  1  one-cycle pulse; load data or store acknowledge
- data_rdata  out  DW  load data; valid with data_rvalid
- bus_req  out  1  bus request
- bus_wr  out  1  write (|wstrb)
- bus_wstrb  out  4  byte strobes
- bus_addr  out  AW  address
- bus_wdata  out  DW  write data
- bus_addr_ok  in  1  address accepted
- bus_data_ok  in  1  response/ack
- bus_rdata  in  DW  read data
- stallreq  out  1  to pipeline controller; asserted = stall the front end

## Operation
- FSM states:
  - IDLE: no transaction.
  - ADDR: bus_req held with the latched request until bus_addr_ok.
  - WAIT: waiting for bus_data_ok.
- Capture: when a capture slot exists, pick one winner and latch its addr/wen/wdata and an owner bit. Assert that requester's gnt combinationally in the same cycle, then go to ADDR.
  - A capture slot is IDLE, or WAIT with bus_data_ok high.
  - In WAIT, a capture happens only if some req is high; otherwise the FSM goes to IDLE.
- Priority (default): data over inst.
- ADDR: bus_req=1 and the bus_* outputs come from the latch. On bus_addr_ok go to WAIT. bus_data_ok is ignored in ADDR.
- WAIT: bus_req=0. On bus_data_ok, pulse owner's rvalid and drive owner's rdata=bus_rdata. Stores also pulse data_rvalid, with data_rdata = bus_rdata (don't-care).
- Non-owner rvalid stays 0. rdata outputs are registered and hold their last value between pulses.
- stallreq = (inst_req & ~inst_gnt) | (data_req & ~data_gnt) | (state!=IDLE & ~bus_data_ok).
- Reset: state=IDLE.
  - Outputs forced to 0: bus_req, gnt, rvalid, stallreq contribution from state.
  - Cleared to 0: bus_* and rdata.
- bus_data_ok arriving in IDLE (a stale response after a mid-transaction reset) is dropped.

## Timing
- Capture cycle C with gnt. Earliest bus_addr_ok is C+1, earliest bus_data_ok is C+2, and rvalid is asserted the same cycle as bus_data_ok.
- Back-to-back: the next request is captured in the data_ok cycle, with no IDLE bubble.
- A simultaneous req from both requesters gives exactly one gnt. The loser keeps req asserted and stallreq stays 1.
- At most one outstanding transaction.

## Configuration
- MEM_ARB_RR_EN defined: round-robin priority. A 1-bit last-owner register, updated on every capture, makes the previous owner lose ties. It resets to "inst last", so data wins the first tie.
- Undefined: fixed data-over-inst priority, with no last-owner register.

## Structure
- Shared package/defines header holds:
  - FSM state encodings (IDLE=2'd0, ADDR=2'd1, WAIT=2'd2)
  - owner encoding (OWN_INST=0, OWN_DATA=1)
  - bus width constants
- Sub-module mem_arb_pick: combinational winner selection from the two reqs and the last-owner bit; the RR macro applies inside it.

## Test plan
- Single load: data_req, addr 0x100. Slave gives addr_ok at C+1 and data_ok at C+3 with rdata 0xDEADBEEF → data_gnt@C, bus_req C+1 only, data_rvalid@C+3 with 0xDEADBEEF, inst_rvalid 0.
- Store: data_wen 4'b0011, wdata 0x1234. Expect bus_wr=1, wstrb 0011, bus_wdata 0x1234, and a data_rvalid pulse on data_ok.
- Contention: inst_req and data_req both high at C → data_gnt@C, inst_gnt in the data_ok cycle of the first transaction, stallreq=1 throughout until inst rvalid.
- RR (MEM_ARB_RR_EN): both reqs held continuously for 4 transactions → owners alternate D,I,D,I.
- Mid-operation reset: rst in WAIT, then data_ok the next cycle → no rvalid; state IDLE; bus_req 0.
- Slave delays addr_ok 5 cycles → bus_req, bus_addr and bus_wdata stay stable, no second gnt.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the IF/MEM bus arbiter
//
// Holds the arbiter FSM state encoding, the owner encoding used by the
// capture latch and the winner selector, and the default bus widths.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie breaking).

package mem_arb_pkg;

   localparam int BUS_AW = 32;
   localparam int BUS_DW = 32;
   localparam int BUS_SW = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection for mem_arb
//
// Ports:
//   inst_req, data_req : pending requests from fetch and MEM stage
//   last_owner         : owner of the previous capture (MEM_ARB_RR_EN only)
//   any_req            : at least one request is pending
//   winner             : owner encoding of the requester to capture
// Macro MEM_ARB_RR_EN: ties go to whoever did not own the last capture;
// otherwise the data requester always wins a tie.

module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic inst_req,
   input  logic data_req,
`ifdef MEM_ARB_RR_EN
   input  logic last_owner,
`endif
   output logic any_req,
   output logic winner
);

   always_comb begin
      any_req = inst_req | data_req;
      winner  = OWN_DATA;
`ifdef MEM_ARB_RR_EN
      if (inst_req && data_req)
         winner = (last_owner == OWN_DATA) ? OWN_INST : OWN_DATA;
      else if (inst_req)
         winner = OWN_INST;
`else
      if (inst_req && !data_req)
         winner = OWN_INST;
`endif
   end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-to-one fetch/data arbiter for the shared SRAM-like bus
//
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   inst_req/addr -> inst_gnt/rvalid/rdata : fetch requester
//   data_req/wen/addr/wdata -> data_gnt/rvalid/rdata : load/store requester
//   bus_req/wr/wstrb/addr/wdata, bus_addr_ok/data_ok/rdata : memory bus
//   stallreq                         : stall request to pipeline controller
// Macro MEM_ARB_RR_EN: round-robin tie breaking with a last-owner register.

module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int AW = BUS_AW,
   parameter int DW = BUS_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inst_req,
   input  logic [AW-1:0] inst_addr,
   output logic          inst_gnt,
   output logic          inst_rvalid,
   output logic [DW-1:0] inst_rdata,
   input  logic          data_req,
   input  logic [3:0]    data_wen,
   input  logic [AW-1:0] data_addr,
   input  logic [DW-1:0] data_wdata,
   output logic          data_gnt,
   output logic          data_rvalid,
   output logic [DW-1:0] data_rdata,
   output logic          bus_req,
   output logic          bus_wr,
   output logic [3:0]    bus_wstrb,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   input  logic          bus_addr_ok,
   input  logic          bus_data_ok,
   input  logic [DW-1:0] bus_rdata,
   output logic          stallreq
);

   state_t          state, state_nxt;
   logic            owner;
   logic [AW-1:0]   addr_q;
   logic [3:0]      wstrb_q;
   logic [DW-1:0]   wdata_q;
   logic [DW-1:0]   inst_rdata_q, data_rdata_q;
   logic            any_req, winner, done, capture;

   // A response completing in WAIT frees the slot in the same cycle, so the
   // next request is captured without passing through IDLE.
   assign done    = (state == S_WAIT) && bus_data_ok;
   assign capture = !rst && any_req && ((state == S_IDLE) || done);

`ifdef MEM_ARB_RR_EN
   logic last_owner;

   always_ff @(posedge clk) begin
      if (rst)
         last_owner <= OWN_INST;
      else if (capture)
         last_owner <= winner;
   end
`endif

   mem_arb_pick u_pick (
      .inst_req   (inst_req),
      .data_req   (data_req),
`ifdef MEM_ARB_RR_EN
      .last_owner (last_owner),
`endif
      .any_req    (any_req),
      .winner     (winner)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (any_req) state_nxt = S_ADDR;
         S_ADDR:  if (bus_addr_ok) state_nxt = S_WAIT;
         S_WAIT:  if (bus_data_ok) state_nxt = any_req ? S_ADDR : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus_req     = 1'b0;
      inst_gnt    = 1'b0;
      data_gnt    = 1'b0;
      inst_rvalid = 1'b0;
      data_rvalid = 1'b0;
      if (!rst) begin
         bus_req     = (state == S_ADDR);
         inst_gnt    = capture && (winner == OWN_INST);
         data_gnt    = capture && (winner == OWN_DATA);
         inst_rvalid = done && (owner == OWN_INST);
         data_rvalid = done && (owner == OWN_DATA);
      end
   end

   // Request latch: the bus sees only this copy, so requesters may change
   // their inputs freely once granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner   <= OWN_INST;
         addr_q  <= '0;
         wstrb_q <= '0;
         wdata_q <= '0;
      end else if (capture) begin
         owner <= winner;
         if (winner == OWN_DATA) begin
            addr_q  <= data_addr;
            wstrb_q <= data_wen;
            wdata_q <= data_wdata;
         end else begin
            addr_q  <= inst_addr;
            wstrb_q <= '0;
            wdata_q <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         if (inst_rvalid) inst_rdata_q <= bus_rdata;
         if (data_rvalid) data_rdata_q <= bus_rdata;
      end
   end

   // Response data passes straight through in the pulse cycle and the
   // register keeps it visible afterwards.
   assign inst_rdata = inst_rvalid ? bus_rdata : inst_rdata_q;
   assign data_rdata = data_rvalid ? bus_rdata : data_rdata_q;

   assign bus_addr  = addr_q;
   assign bus_wstrb = wstrb_q;
   assign bus_wdata = wdata_q;
   assign bus_wr    = |wstrb_q;

   assign stallreq = (inst_req & ~inst_gnt) | (data_req & ~data_gnt) |
                     ((state != S_IDLE) & ~bus_data_ok & ~rst);

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - scoreboard testbench for mem_arb

module tb_mem_arb;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wen;
      logic [31:0] wdata;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_gnt, inst_rvalid;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_req, data_gnt, data_rvalid;
   logic [3:0]  data_wen;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok, stallreq;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   cmd_t icmd_q[$], dcmd_q[$], iexp_q[$], dexp_q[$];
   logic gnt_log[$];
   int   addr_dly = 0, data_dly = 0;
   int   dgnt_cyc, ignt_cyc, drv_cyc, irv_cyc;
   int   breq_cnt = 0, irv_cnt = 0, gnt_cnt = 0;
   int   st_hi = 0, st_lo = 0;
   logic watch = 1'b0;
   logic [31:0] cur_addr, cur_wdata;
   logic [3:0]  cur_wstrb;
   logic        cur_wr;

   mem_arb dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
      .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
      .data_rdata(data_rdata),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
      .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .stallreq(stallreq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] rd_of(input logic [31:0] a);
      return a ^ 32'hDEADBFEF;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // bus slave: addr_ok after addr_dly cycles of bus_req, data_ok data_dly cycles later
   initial begin
      int sst = 0;
      int cnt = 0;
      logic [31:0] a = 0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
      forever begin
         @(posedge clk); #1;
         bus_addr_ok = 1'b0;
         bus_data_ok = 1'b0;
         if (sst == 0) begin
            if (bus_req) begin
               if (cnt >= addr_dly) begin
                  bus_addr_ok = 1'b1; a = bus_addr; sst = 1; cnt = 0;
               end else cnt++;
            end
         end else begin
            if (cnt >= data_dly) begin
               bus_data_ok = 1'b1; bus_rdata = rd_of(a); sst = 0; cnt = 0;
            end else cnt++;
         end
      end
   end

   // requester drivers: keep req high while commands remain queued
   initial begin
      cmd_t c;
      int n;
      inst_req = 1'b0; inst_addr = '0;
      forever begin
         @(posedge clk); #1;
         if (icmd_q.size() == 0) inst_req = 1'b0;
         else begin
            c = icmd_q.pop_front();
            inst_req = 1'b1; inst_addr = c.addr;
            iexp_q.push_back(c);
            n = 0;
            do begin @(negedge clk); n++; end while (!inst_gnt && n < 500);
            if (!inst_gnt) check("inst_gnt_timeout", 0, 1);
         end
      end
   end

   initial begin
      cmd_t c;
      int n;
      data_req = 1'b0; data_addr = '0; data_wen = '0; data_wdata = '0;
      forever begin
         @(posedge clk); #1;
         if (dcmd_q.size() == 0) data_req = 1'b0;
         else begin
            c = dcmd_q.pop_front();
            data_req = 1'b1; data_addr = c.addr; data_wen = c.wen; data_wdata = c.wdata;
            dexp_q.push_back(c);
            n = 0;
            do begin @(negedge clk); n++; end while (!data_gnt && n < 500);
            if (!data_gnt) check("data_gnt_timeout", 0, 1);
         end
      end
   end

   // monitor: grants, bus address phase, responses checked against the scoreboard
   initial begin
      cmd_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (inst_gnt && data_gnt) check("double_gnt", 1, 0);
            if (data_gnt) begin gnt_log.push_back(1'b1); dgnt_cyc = cyc; gnt_cnt++; end
            if (inst_gnt) begin gnt_log.push_back(1'b0); ignt_cyc = cyc; gnt_cnt++; end
            if (bus_req) breq_cnt++;
            if (bus_req && bus_addr_ok) begin
               cur_addr = bus_addr; cur_wdata = bus_wdata; cur_wstrb = bus_wstrb; cur_wr = bus_wr;
            end
            if (watch) begin
               if (inst_rvalid) watch = 1'b0;
               else if (stallreq) st_hi++;
               else if (!bus_data_ok) st_lo++;
            end
            if (inst_rvalid) begin
               irv_cnt++; irv_cyc = cyc;
               if (iexp_q.size() == 0) check("inst_rvalid_unexpected", 1, 0);
               else begin
                  e = iexp_q.pop_front();
                  check("inst_rdata", inst_rdata, rd_of(e.addr));
                  check("inst_bus_addr", cur_addr, e.addr);
                  check("inst_bus_wr", cur_wr, 0);
               end
            end
            if (data_rvalid) begin
               drv_cyc = cyc;
               if (dexp_q.size() == 0) check("data_rvalid_unexpected", 1, 0);
               else begin
                  e = dexp_q.pop_front();
                  check("data_rdata", data_rdata, rd_of(e.addr));
                  check("data_bus_addr", cur_addr, e.addr);
                  check("data_bus_wstrb", cur_wstrb, e.wen);
                  check("data_bus_wr", cur_wr, |e.wen);
                  if (e.wen != 0) check("data_bus_wdata", cur_wdata, e.wdata);
               end
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      do begin @(negedge clk); n++; end
      while ((icmd_q.size() + dcmd_q.size() + iexp_q.size() + dexp_q.size() != 0 ||
              inst_req || data_req || bus_req) && n < 300);
      if (n >= 300) check("idle_timeout", 0, 1);
      @(negedge clk);
   endtask

   task automatic wait_data_gnt(input string tag);
      int n = 0;
      do begin @(negedge clk); n++; end while (!data_gnt && n < 50);
      check(tag, data_gnt, 1);
   endtask

   initial begin
      logic exp_own [4];
      int n, unstable, g0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_bus_req", bus_req, 0);
      check("rst_stallreq", stallreq, 0);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_data_rdata", data_rdata, 0);
      check("rst_inst_rdata", inst_rdata, 0);
      @(posedge clk); #1 rst = 1'b0;

      // single load, data_ok at C+3
      data_dly = 1;
      @(negedge clk);
      breq_cnt = 0; irv_cnt = 0;
      dcmd_q.push_back('{32'h100, 4'h0, 32'h0});
      wait_idle();
      check("t1_latency", 64'(drv_cyc - dgnt_cyc), 3);
      check("t1_bus_req_cycles", 64'(breq_cnt), 1);
      check("t1_inst_rvalid", 64'(irv_cnt), 0);
      check("t1_rdata_hold", data_rdata, 32'hDEADBEEF);

      // store
      data_dly = 0;
      dcmd_q.push_back('{32'h200, 4'b0011, 32'h1234});
      wait_idle();
      check("t2_latency", 64'(drv_cyc - dgnt_cyc), 2);

      // contention: data first, inst captured in the data_ok cycle
      @(negedge clk);
      gnt_log.delete(); st_hi = 0; st_lo = 0;
      dcmd_q.push_back('{32'h240, 4'h0, 32'h0});
      icmd_q.push_back('{32'h1000, 4'h0, 32'h0});
      watch = 1'b1;
      wait_idle();
      check("t3_gnt_count", 64'(gnt_log.size()), 2);
      if (gnt_log.size() >= 2) begin
         check("t3_first_owner", gnt_log[0], 1);
         check("t3_second_owner", gnt_log[1], 0);
      end
      check("t3_inst_gnt_at_data_ok", 64'(ignt_cyc), 64'(drv_cyc));
      check("t3_stall_low", 64'(st_lo), 0);
      check("t3_stall_high", 64'(st_hi), 3);

      // both requesters held for four transactions
`ifdef MEM_ARB_RR_EN
      exp_own = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_own = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
      @(negedge clk);
      gnt_log.delete();
      dcmd_q.push_back('{32'h300, 4'h0, 32'h0});
      dcmd_q.push_back('{32'h304, 4'b1100, 32'hA5A50000});
      icmd_q.push_back('{32'h1004, 4'h0, 32'h0});
      icmd_q.push_back('{32'h1008, 4'h0, 32'h0});
      wait_idle();
      check("t4_gnt_count", 64'(gnt_log.size()), 4);
      if (gnt_log.size() >= 4)
         for (int i = 0; i < 4; i++) check($sformatf("t4_owner%0d", i), gnt_log[i], exp_own[i]);

      // slow addr_ok: latch stable, no second grant while waiting
      addr_dly = 5;
      @(negedge clk);
      dcmd_q.push_back('{32'h380, 4'hF, 32'hCAFEF00D});
      wait_data_gnt("t6_gnt_seen");
      icmd_q.push_back('{32'h100C, 4'h0, 32'h0});
      g0 = gnt_cnt; n = 0; unstable = 0;
      do begin
         @(negedge clk);
         if (!bus_req || !stallreq || bus_addr !== 32'h380 ||
             bus_wdata !== 32'hCAFEF00D || bus_wstrb !== 4'hF) unstable++;
         n++;
      end while (!bus_addr_ok && n < 20);
      check("t6_addr_wait_cycles", 64'(n), 6);
      check("t6_unstable", 64'(unstable), 0);
      check("t6_extra_gnt", 64'(gnt_cnt - g0), 0);
      wait_idle();
      check("t6_inst_gnt_at_data_ok", 64'(ignt_cyc), 64'(drv_cyc));
      addr_dly = 0;

      // reset in WAIT, stale data_ok the next cycle
      data_dly = 1;
      @(negedge clk);
      dcmd_q.push_back('{32'h3C0, 4'h0, 32'h0});
      wait_data_gnt("t5_gnt_seen");
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1'b1;
      void'(dexp_q.pop_back());
      @(negedge clk);
      check("t5_rst_bus_req", bus_req, 0);
      check("t5_rst_stallreq", stallreq, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("t5_stale_data_rvalid", data_rvalid, 0);
      check("t5_stale_inst_rvalid", inst_rvalid, 0);
      check("t5_stale_stallreq", stallreq, 0);
      check("t5_data_rdata_clr", data_rdata, 0);
      check("t5_bus_addr_clr", bus_addr, 0);
      @(negedge clk);
      check("t5_idle_bus_req", bus_req, 0);

      // recovery after reset
      data_dly = 0;
      dcmd_q.push_back('{32'h500, 4'h0, 32'h0});
      wait_idle();
      check("t7_latency", 64'(drv_cyc - dgnt_cyc), 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
